// File: rtl/udma_i2c_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module      : udma_i2c_bus_pkg
// Description : Shared types and default constants for the I2C bus monitor.
// Revision    : 1.0 - initial release
// ============================================================================
package udma_i2c_bus_pkg;

   localparam int c_SYNC_STAGES_DEFAULT = 2;
   localparam int c_FILTER_LEN_DEFAULT  = 3;
   localparam int c_FILT_CNT_W          = 4;
   localparam int c_TO_CNT_W            = 16;

   typedef enum logic [0:0] {
      ST_IDLE = 1'b0,
      ST_BUSY = 1'b1
   } bus_state_e;

endpackage
`default_nettype wire

// File: rtl/udma_i2c_line_filter.sv
`default_nettype none
// ============================================================================
// Module      : udma_i2c_line_filter
// Description : Synchroniser plus consecutive-sample glitch filter, one line.
// Revision    : 1.0 - initial release
// ============================================================================
module udma_i2c_line_filter
   import udma_i2c_bus_pkg::*;
#(
   parameter int SYNC_STAGES = c_SYNC_STAGES_DEFAULT,
   parameter int FILTER_LEN  = c_FILTER_LEN_DEFAULT
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic line_i,
   output logic filt_o
);

   localparam int c_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam int c_LEN    = (FILTER_LEN < 1) ? 1 :
                             ((FILTER_LEN > 15) ? 15 : FILTER_LEN);
   localparam logic [c_FILT_CNT_W-1:0] c_LEN_M1 = c_FILT_CNT_W'(c_LEN - 1);

   logic [c_STAGES-1:0]     r_sync;
   logic [c_FILT_CNT_W-1:0] r_cnt;
   logic                    r_filt;
   logic                    w_sync;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sync <= '1;
      end else begin
         r_sync <= {r_sync[c_STAGES-2:0], line_i};
      end
   end

   assign w_sync = r_sync[c_STAGES-1];

   // Any sample agreeing with the current output restarts the run count.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt  <= '0;
         r_filt <= 1'b1;
      end else if (w_sync != r_filt) begin
         if (r_cnt == c_LEN_M1) begin
            r_filt <= ~r_filt;
            r_cnt  <= '0;
         end else begin
            r_cnt <= r_cnt + 1'b1;
         end
      end else begin
         r_cnt <= '0;
      end
   end

   assign filt_o = r_filt;

endmodule
`default_nettype wire

// File: rtl/udma_i2c_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module      : udma_i2c_bus_monitor
// Description : Pad-side I2C conditioner: filtering, START/STOP, busy, arb-lost.
//               Optional SCL-low timeout enabled by UDMA_I2C_BUS_TIMEOUT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module udma_i2c_bus_monitor
   import udma_i2c_bus_pkg::*;
#(
   parameter int SYNC_STAGES    = c_SYNC_STAGES_DEFAULT,
   parameter int FILTER_LEN     = c_FILTER_LEN_DEFAULT,
   parameter int TIMEOUT_CYCLES = 65535
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic scl_i,
   input  logic sda_i,
   input  logic sda_o_i,
   input  logic sda_oe_i,
   input  logic master_active_i,
   input  logic al_clr_i,
   output logic scl_filt_o,
   output logic sda_filt_o,
   output logic start_det_o,
   output logic stop_det_o,
   output logic bus_busy_o,
   output logic arb_lost_o,
   output logic timeout_o
);

   localparam logic [c_TO_CNT_W-1:0] c_TO_LIMIT =
      (TIMEOUT_CYCLES < 1)     ? c_TO_CNT_W'(1) :
      (TIMEOUT_CYCLES > 65535) ? c_TO_CNT_W'(65535) :
                                 c_TO_CNT_W'(TIMEOUT_CYCLES);

   logic       w_scl_filt;
   logic       w_sda_filt;
   logic       r_scl_q;
   logic       r_sda_q;
   logic       w_start;
   logic       w_stop;
   logic       w_scl_rise;
   logic       w_drive_low;
   logic       w_al_set;
   logic       w_to_force;
   bus_state_e r_state;
   logic       r_busy;
   logic       r_start;
   logic       r_stop;
   logic       r_al;

   udma_i2c_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_scl_filter (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .line_i (scl_i),
      .filt_o (w_scl_filt)
   );

   udma_i2c_line_filter #(
      .SYNC_STAGES (SYNC_STAGES),
      .FILTER_LEN  (FILTER_LEN)
   ) u_sda_filter (
      .clk_i  (clk_i),
      .rst_i  (rst_i),
      .line_i (sda_i),
      .filt_o (w_sda_filt)
   );

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_scl_q <= 1'b1;
         r_sda_q <= 1'b1;
      end else begin
         r_scl_q <= w_scl_filt;
         r_sda_q <= w_sda_filt;
      end
   end

   // Requiring SCL high in both cycles suppresses events when SCL and SDA
   // move together.
   assign w_start     = r_scl_q & w_scl_filt &  r_sda_q & ~w_sda_filt;
   assign w_stop      = r_scl_q & w_scl_filt & ~r_sda_q &  w_sda_filt;
   assign w_scl_rise  = ~r_scl_q & w_scl_filt;
   assign w_drive_low = sda_oe_i & ~sda_o_i;
   assign w_al_set    = master_active_i &
                        ((w_scl_rise & ~w_drive_low & ~w_sda_filt) |
                         ((w_start | w_stop) & ~sda_oe_i));

`ifdef UDMA_I2C_BUS_TIMEOUT_EN
   logic [c_TO_CNT_W-1:0] r_to_cnt;
   logic                  r_timeout;
   logic                  w_to_count;

   assign w_to_count = r_busy & ~w_scl_filt;
   assign w_to_force = w_to_count & (r_to_cnt == (c_TO_LIMIT - 1'b1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_to_cnt  <= '0;
         r_timeout <= 1'b0;
      end else begin
         if (w_to_count) begin
            if (r_to_cnt != c_TO_LIMIT) begin
               r_to_cnt <= r_to_cnt + 1'b1;
            end
         end else begin
            r_to_cnt <= '0;
         end
         if (w_start) begin
            r_timeout <= 1'b0;
         end else if (w_to_force) begin
            r_timeout <= 1'b1;
         end
      end
   end

   assign timeout_o = r_timeout;
`else
   logic w_unused_timeout_cfg;

   assign w_unused_timeout_cfg = ^c_TO_LIMIT;
   assign w_to_force           = 1'b0;
   assign timeout_o            = 1'b0;
`endif

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= ST_IDLE;
         r_busy  <= 1'b0;
         r_start <= 1'b0;
         r_stop  <= 1'b0;
      end else begin
         r_start <= w_start;
         r_stop  <= w_stop;
         if (w_to_force) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (w_start) begin
                     r_state <= ST_BUSY;
                     r_busy  <= 1'b1;
                  end
               end
               ST_BUSY: begin
                  if (w_stop) begin
                     r_state <= ST_IDLE;
                     r_busy  <= 1'b0;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   // Set takes priority over a coincident clear.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_al <= 1'b0;
      end else if (w_al_set) begin
         r_al <= 1'b1;
      end else if (al_clr_i) begin
         r_al <= 1'b0;
      end
   end

   assign scl_filt_o  = w_scl_filt;
   assign sda_filt_o  = w_sda_filt;
   assign start_det_o = r_start;
   assign stop_det_o  = r_stop;
   assign bus_busy_o  = r_busy;
   assign arb_lost_o  = r_al;

endmodule
`default_nettype wire

// File: tb/tb_udma_i2c_bus_monitor.sv
`default_nettype none
// ============================================================================
// Module      : tb_udma_i2c_bus_monitor
// Description : Directed self-checking bench for udma_i2c_bus_monitor.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_udma_i2c_bus_monitor;

   logic clk = 1'b0;
   logic rst, scl, sda, sda_o, sda_oe, master_active, al_clr;
   logic scl_filt, sda_filt, start_det, stop_det, bus_busy, arb_lost, timeout;

   int n_checks = 0;
   int n_errors = 0;
   logic seen_start, seen_stop, seen_sda_low;

`ifdef UDMA_I2C_BUS_TIMEOUT_EN
   localparam logic c_TO_EXP   = 1'b1;
   localparam logic c_BUSY_EXP = 1'b0;
`else
   localparam logic c_TO_EXP   = 1'b0;
   localparam logic c_BUSY_EXP = 1'b1;
`endif

   always #5 clk = ~clk;

   udma_i2c_bus_monitor #(
      .SYNC_STAGES    (2),
      .FILTER_LEN     (3),
      .TIMEOUT_CYCLES (100)
   ) dut (
      .clk_i           (clk),
      .rst_i           (rst),
      .scl_i           (scl),
      .sda_i           (sda),
      .sda_o_i         (sda_o),
      .sda_oe_i        (sda_oe),
      .master_active_i (master_active),
      .al_clr_i        (al_clr),
      .scl_filt_o      (scl_filt),
      .sda_filt_o      (sda_filt),
      .start_det_o     (start_det),
      .stop_det_o      (stop_det),
      .bus_busy_o      (bus_busy),
      .arb_lost_o      (arb_lost),
      .timeout_o       (timeout)
   );

   task automatic check(input string tag, input logic got, input logic exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %b expected %b", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic watch(input int n);
      seen_start   = 1'b0;
      seen_stop    = 1'b0;
      seen_sda_low = 1'b0;
      repeat (n) begin
         @(negedge clk);
         seen_start   = seen_start | start_det;
         seen_stop    = seen_stop | stop_det;
         seen_sda_low = seen_sda_low | ~sda_filt;
      end
   endtask

   initial begin
      rst = 1'b1; scl = 1'b1; sda = 1'b1; sda_o = 1'b1; sda_oe = 1'b0;
      master_active = 1'b0; al_clr = 1'b0;
      tick(3);
      check("rst_scl_filt", scl_filt, 1'b1);
      check("rst_sda_filt", sda_filt, 1'b1);
      check("rst_busy", bus_busy, 1'b0);
      check("rst_arb", arb_lost, 1'b0);
      check("rst_timeout", timeout, 1'b0);
      rst = 1'b0;
      watch(8);
      check("rel_no_start", seen_start, 1'b0);
      check("rel_no_stop", seen_stop, 1'b0);
      check("rel_busy", bus_busy, 1'b0);

      // 2-clock SDA glitch must be swallowed
      sda = 1'b0; tick(2); sda = 1'b1;
      watch(10);
      check("glitch_sda", seen_sda_low, 1'b0);
      check("glitch_start", seen_start, 1'b0);

      // START: filtered edge after 5 clocks, pulse one clock later
      sda = 1'b0;
      tick(4); check("start_lat4", sda_filt, 1'b1);
      tick(1); check("start_lat5", sda_filt, 1'b0);
      check("start_not_yet", start_det, 1'b0);
      tick(1); check("start_pulse", start_det, 1'b1);
      check("start_busy", bus_busy, 1'b1);
      tick(1); check("start_single", start_det, 1'b0);
      check("start_busy_hold", bus_busy, 1'b1);

      // Repeated START
      scl = 1'b0; tick(6); sda = 1'b1; tick(6); scl = 1'b1;
      watch(6);
      check("rs_scl_rise_no_evt", seen_start | seen_stop, 1'b0);
      sda = 1'b0; tick(6);
      check("rs_pulse", start_det, 1'b1);
      check("rs_busy", bus_busy, 1'b1);

      // STOP
      sda = 1'b1;
      tick(5); check("stop_busy_before", bus_busy, 1'b1);
      tick(1); check("stop_pulse", stop_det, 1'b1);
      check("stop_idle", bus_busy, 1'b0);
      tick(1); check("stop_single", stop_det, 1'b0);

      // Arbitration loss at SCL rise with external SDA low
      scl = 1'b0; tick(6); sda = 1'b0; tick(6);
      master_active = 1'b1; sda_oe = 1'b0;
      scl = 1'b1;
      tick(5); check("al_pre", arb_lost, 1'b0);
      tick(1); check("al_set", arb_lost, 1'b1);
      tick(5); check("al_sticky", arb_lost, 1'b1);
      al_clr = 1'b1; tick(1); al_clr = 1'b0;
      check("al_clear", arb_lost, 1'b0);

      // Set and clear in the same cycle
      scl = 1'b0; tick(6); scl = 1'b1;
      tick(5); check("al_pre2", arb_lost, 1'b0);
      al_clr = 1'b1; tick(1); al_clr = 1'b0;
      check("al_set_wins", arb_lost, 1'b1);
      al_clr = 1'b1; tick(1); al_clr = 1'b0;
      check("al_clear2", arb_lost, 1'b0);

      // We drive SDA low ourselves: no arbitration loss
      sda_oe = 1'b1; sda_o = 1'b0;
      scl = 1'b0; tick(6); scl = 1'b1;
      watch(8);
      check("al_own_low", arb_lost, 1'b0);

      // STOP in IDLE while master active and not driving
      sda_oe = 1'b0; sda_o = 1'b1;
      sda = 1'b1; tick(6);
      check("idle_stop_pulse", stop_det, 1'b1);
      check("idle_stop_busy", bus_busy, 1'b0);
      check("al_on_stop", arb_lost, 1'b1);
      master_active = 1'b0;
      al_clr = 1'b1; tick(1); al_clr = 1'b0;

      // SCL held low while busy
      sda = 1'b0; tick(6);
      check("to_busy", bus_busy, 1'b1);
      scl = 1'b0;
      tick(104);
      check("to_early", timeout, 1'b0);
      check("to_early_busy", bus_busy, 1'b1);
      tick(1);
      check("to_flag", timeout, c_TO_EXP);
      check("to_busy_after", bus_busy, c_BUSY_EXP);
      scl = 1'b1; tick(6);
      sda = 1'b1; tick(6);
      check("to_stop", stop_det, 1'b1);
      sda = 1'b0; tick(6);
      check("to_clr_start", start_det, 1'b1);
      check("to_clr", timeout, 1'b0);
      check("to_clr_busy", bus_busy, 1'b1);

      // Asynchronous reset mid-transfer
      scl = 1'b0; tick(6);
      check("mid_scl_low", scl_filt, 1'b0);
      rst = 1'b1; #1;
      check("mid_rst_scl", scl_filt, 1'b1);
      check("mid_rst_sda", sda_filt, 1'b1);
      check("mid_rst_busy", bus_busy, 1'b0);
      scl = 1'b1; sda = 1'b1;
      tick(3);
      rst = 1'b0;
      watch(8);
      check("mid_rel_events", seen_start | seen_stop, 1'b0);
      check("mid_rel_busy", bus_busy, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
